// File: rtl/mips_pipeline_exmem_sequencer.sv
// EX->MEM sequencer: launches one data-memory request at a time and commits results to MEM/WB.
// Latency: ALU results are committed 1 cycle after accept; memory ops take at least 2 cycles (accept, ack, commit).
// Backpressure: stall is high while a request is outstanding; a bus timeout raises a sticky fault and drops the request.
module mips_pipeline_exmem_sequencer #(
  parameter int WORD    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exValid,
  input  logic            exLoad,
  input  logic            exStore,
  input  logic [WORD-1:0] exAddr,
  input  logic [WORD-1:0] exData,
  input  logic            flush,
  output logic            memReq,
  output logic            memWrite,
  output logic [WORD-1:0] memAddr,
  output logic [WORD-1:0] memWdata,
  input  logic            memAck,
  input  logic [WORD-1:0] memRdata,
  output logic            stall,
  output logic            wbValid,
  output logic [WORD-1:0] wbData,
  output logic            fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  logic [7:0]      r_waitCount;
  logic            r_kill;      // current memory op was flushed; its result must not commit
  logic            r_aluVld;    // one-cycle commit pulse for pass-through results
  logic            r_memReq;
  logic            r_memWrite;
  logic [WORD-1:0] r_memAddr;
  logic [WORD-1:0] r_memWdata;
  logic [WORD-1:0] r_wbData;
  logic            r_fault;

  logic            w_launch;
  logic            w_timeout;

  // A memory op is launched only from IDLE by a valid, unflushed load/store.
  assign w_launch  = (r_state == S_IDLE) && exValid && (exLoad || exStore) && !flush;
  assign w_timeout = (r_waitCount == 8'(TIMEOUT - 1));

  // Upstream must hold in the launch cycle and for every cycle the bus is busy.
  assign stall    = !reset && ((r_state == S_WAIT) || w_launch);
  // Memory results commit during DONE; a flush arriving in DONE itself still cancels the commit.
  assign wbValid  = r_aluVld || ((r_state == S_DONE) && !r_kill && !flush);
  assign wbData   = r_wbData;
  assign memReq   = r_memReq;
  assign memWrite = r_memWrite;
  assign memAddr  = r_memAddr;
  assign memWdata = r_memWdata;
  assign fault    = r_fault;

  // Sequencer FSM with registered bus and writeback outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_waitCount <= '0;
      r_kill      <= 1'b0;
      r_aluVld    <= 1'b0;
      r_memReq    <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_wbData    <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_aluVld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exValid && !flush) begin
            if (exLoad || exStore) begin
              r_memReq    <= 1'b1;
              r_memWrite  <= exStore;
              r_memAddr   <= exAddr;
              r_memWdata  <= exData;
              r_waitCount <= '0;
              r_kill      <= 1'b0;
              r_state     <= S_WAIT;
            end else begin
              r_aluVld <= 1'b1;
              r_wbData <= exData;
            end
          end
        end
        S_WAIT: begin
          // The bus is never abandoned on flush; only the eventual result is dropped.
          r_kill <= r_kill || flush;
          if (memAck) begin
            r_memReq <= 1'b0;
            r_state  <= S_DONE;
            if (!(r_kill || flush)) begin
              r_wbData <= r_memWrite ? r_memWdata : memRdata;
            end
          end else if (w_timeout) begin
            r_memReq <= 1'b0;
            r_fault  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_waitCount <= r_waitCount + 8'd1;
          end
        end
        S_DONE: begin
          // EX still holds the completed instruction this cycle, so nothing is accepted here.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_pipeline_exmem_sequencer.sv
// Self-checking bench for mips_pipeline_exmem_sequencer with a writeback scoreboard.
// Inputs change 1 ns after the rising edge; the scoreboard samples on the falling edge.
// Expected writeback values are queued as stimulus is applied and popped on every wbValid.
module tb_mips_pipeline_exmem_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        exValid, exLoad, exStore, flush;
  logic [31:0] exAddr, exData;
  logic        memReq, memWrite, memAck;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        stall, wbValid, fault;
  logic [31:0] wbData;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

  mips_pipeline_exmem_sequencer #(.WORD(32), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .exValid(exValid), .exLoad(exLoad), .exStore(exStore),
    .exAddr(exAddr), .exData(exData), .flush(flush),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWdata(memWdata),
    .memAck(memAck), .memRdata(memRdata),
    .stall(stall), .wbValid(wbValid), .wbData(wbData), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    exValid = 0; exLoad = 0; exStore = 0; flush = 0;
    exAddr = '0; exData = '0; memAck = 0; memRdata = '0;
  endtask

  // Scoreboard: every commit must match the oldest expected result.
  always @(negedge clock) begin
    if (!reset && wbValid) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else                  chk("wbData", wbData, sb_q.pop_front());
    end
  end

  initial begin
    clr_inputs();
    reset = 1;
    // A load presented during reset must not raise stall.
    exValid = 1; exLoad = 1; exAddr = 32'h40;
    #1 chk("rst_stall", {31'd0, stall}, 32'd0);
    cyc(); cyc();
    chk("rst_memReq",  {31'd0, memReq},   32'd0);
    chk("rst_memWrite",{31'd0, memWrite}, 32'd0);
    chk("rst_memAddr", memAddr,           32'd0);
    chk("rst_memWdata",memWdata,          32'd0);
    chk("rst_wbValid", {31'd0, wbValid},  32'd0);
    chk("rst_wbData",  wbData,            32'd0);
    chk("rst_fault",   {31'd0, fault},    32'd0);
    chk("rst_stall2",  {31'd0, stall},    32'd0);
    reset = 0; clr_inputs();
    cyc();

    // Two back-to-back ALU ops: 1-cycle latency, never stall.
    exValid = 1; exData = 32'h0000_0005; sb_q.push_back(32'h0000_0005);
    #1 chk("alu_stall0", {31'd0, stall}, 32'd0);
    cyc();
    exData = 32'h1234_5678; sb_q.push_back(32'h1234_5678);
    #1 chk("alu_wbv0", {31'd0, wbValid}, 32'd1);
    chk("alu_stall1", {31'd0, stall}, 32'd0);
    cyc();
    exValid = 0;
    #1 chk("alu_wbv1", {31'd0, wbValid}, 32'd1);
    cyc();
    #1 chk("alu_wbv_end", {31'd0, wbValid}, 32'd0);

    // Load acknowledged in the 4th WAIT cycle (3 cycles without ack).
    exValid = 1; exLoad = 1; exAddr = 32'h0000_1000;
    #1 chk("ld_launch_stall", {31'd0, stall}, 32'd1);
    cyc();
    clr_inputs();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        memAck = 1; memRdata = 32'hDEAD_BEEF; sb_q.push_back(32'hDEAD_BEEF);
      end
      #1;
      chk("ld_memReq",   {31'd0, memReq},   32'd1);
      chk("ld_memWrite", {31'd0, memWrite}, 32'd0);
      chk("ld_memAddr",  memAddr,           32'h0000_1000);
      chk("ld_stall",    {31'd0, stall},    32'd1);
      cyc();
    end
    clr_inputs();
    #1 chk("ld_done_memReq", {31'd0, memReq}, 32'd0);
    chk("ld_done_stall", {31'd0, stall},   32'd0);
    chk("ld_done_wbv",   {31'd0, wbValid}, 32'd1);
    cyc();

    // Store with immediate ack: wbValid two cycles after accept.
    exValid = 1; exStore = 1; exAddr = 32'h20; exData = 32'hA5A5_A5A5;
    cyc();
    clr_inputs();
    memAck = 1; sb_q.push_back(32'hA5A5_A5A5);
    #1 chk("st_memReq",   {31'd0, memReq},   32'd1);
    chk("st_memWrite",    {31'd0, memWrite}, 32'd1);
    chk("st_memWdata",    memWdata,          32'hA5A5_A5A5);
    chk("st_memAddr",     memAddr,           32'h20);
    cyc();
    memAck = 0;
    #1 chk("st_wbv", {31'd0, wbValid}, 32'd1);
    chk("st_memReq_drop", {31'd0, memReq}, 32'd0);
    cyc();

    // Flush in IDLE: neither a load nor an ALU op is accepted.
    exValid = 1; exLoad = 1; exAddr = 32'h80; flush = 1;
    #1 chk("fli_stall", {31'd0, stall}, 32'd0);
    cyc();
    exLoad = 0; exData = 32'h7777_7777;
    #1 chk("fli_memReq", {31'd0, memReq}, 32'd0);
    cyc();
    clr_inputs();
    #1 chk("fli_wbv", {31'd0, wbValid}, 32'd0);
    cyc();

    // Flush in the 2nd WAIT cycle, ack in the 4th: bus held, result dropped.
    exValid = 1; exLoad = 1; exAddr = 32'h300;
    cyc();
    clr_inputs();
    for (int i = 0; i < 4; i++) begin
      flush  = (i == 1);
      memAck = (i == 3);
      memRdata = 32'hBAD0_BAD0;
      #1 chk("flw_memReq", {31'd0, memReq}, 32'd1);
      chk("flw_stall", {31'd0, stall}, 32'd1);
      cyc();
    end
    clr_inputs();
    #1 chk("flw_memReq_drop", {31'd0, memReq}, 32'd0);
    chk("flw_stall_drop", {31'd0, stall},   32'd0);
    chk("flw_wbv",        {31'd0, wbValid}, 32'd0);
    cyc();

    // Flush arriving in DONE suppresses the store's commit.
    exValid = 1; exStore = 1; exAddr = 32'h44; exData = 32'h0BAD_F00D;
    cyc();
    clr_inputs(); memAck = 1;
    cyc();
    memAck = 0; flush = 1;
    #1 chk("fld_wbv", {31'd0, wbValid}, 32'd0);
    cyc();
    clr_inputs();

    // Ack in the same cycle the timeout would fire: ack wins.
    exValid = 1; exLoad = 1; exAddr = 32'h500;
    cyc();
    clr_inputs();
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        memAck = 1; memRdata = 32'hC0FF_EE00; sb_q.push_back(32'hC0FF_EE00);
      end
      cyc();
    end
    clr_inputs();
    #1 chk("race_fault", {31'd0, fault}, 32'd0);
    chk("race_wbv", {31'd0, wbValid}, 32'd1);
    cyc();

    // Timeout: 15 WAIT cycles without ack raise a sticky fault, no commit.
    exValid = 1; exLoad = 1; exAddr = 32'h600;
    cyc();
    clr_inputs();
    for (int i = 1; i <= 15; i++) begin
      #1 chk("to_memReq", {31'd0, memReq}, 32'd1);
      chk("to_fault_early", {31'd0, fault}, 32'd0);
      cyc();
    end
    #1 chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_memReq_drop", {31'd0, memReq},  32'd0);
    chk("to_stall",       {31'd0, stall},   32'd0);
    chk("to_wbv",         {31'd0, wbValid}, 32'd0);
    // Stray ack outside WAIT is ignored; ALU ops still flow; fault stays set.
    memAck = 1; memRdata = 32'h1111_1111;
    cyc();
    memAck = 0;
    exValid = 1; exData = 32'h0000_00AB; sb_q.push_back(32'h0000_00AB);
    cyc();
    clr_inputs();
    cyc(); cyc();
    #1 chk("to_fault_sticky", {31'd0, fault}, 32'd1);

    // Reset mid-WAIT drops the request; a late ack produces nothing.
    exValid = 1; exLoad = 1; exAddr = 32'h700;
    cyc();
    clr_inputs();
    cyc();
    reset = 1;
    #1 chk("rw_stall", {31'd0, stall}, 32'd0);
    cyc();
    reset = 0;
    #1 chk("rw_memReq", {31'd0, memReq}, 32'd0);
    chk("rw_memAddr", memAddr,           32'd0);
    chk("rw_fault",   {31'd0, fault},    32'd0);
    chk("rw_wbv",     {31'd0, wbValid},  32'd0);
    chk("rw_wbData",  wbData,            32'd0);
    memAck = 1; memRdata = 32'h2222_2222;
    cyc(); cyc();
    clr_inputs();
    cyc(); cyc();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_pipeline_exmem_sequencer.md
MIPS_PIPELINE_EXMEM_SEQUENCER -- requirements
Module: mips_pipeline_exmem_sequencer

Interface
REQ-001 Parameter WORD, default 32: data and address width in bits.
REQ-002 Parameter TIMEOUT, default 15: maximum number of wait cycles for memAck before a bus fault is raised (range 1..255).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 exValid  input  1  EX stage presents a valid instruction this cycle.
REQ-006 exLoad  input  1  EX instruction is a load (qualified by exValid).
REQ-007 exStore  input  1  EX instruction is a store (qualified by exValid); exLoad and exStore are never both 1.
REQ-008 exAddr  input  WORD  ALU result, used as the memory address.
REQ-009 exData  input  WORD  store data, or the non-memory result.
REQ-010 flush  input  1  kill the instruction currently accepted from EX.
REQ-011 memReq  output  1  data-memory request strobe.
REQ-012 memWrite  output  1  1 = store, 0 = load, valid while memReq=1.
REQ-013 memAddr  output  WORD  registered request address.
REQ-014 memWdata  output  WORD  registered store data.
REQ-015 memAck  input  1  memory completes the outstanding request this cycle.
REQ-016 memRdata  input  WORD  load data, valid when memAck=1.
REQ-017 stall  output  1  upstream (IF/ID/EX) holds its registers.
REQ-018 wbValid  output  1  one-cycle pulse: wbData is committed to the MEM/WB register.
REQ-019 wbData  output  WORD  load data or passed-through result.
REQ-020 fault  output  1  sticky bus-timeout flag.

Function
REQ-021 FSM states: IDLE, WAIT, DONE.
REQ-022 IDLE: exValid and not memory op -> wbValid=1 on the next cycle with wbData=exData (1-cycle latency); state stays IDLE; stall=0.
REQ-023 IDLE: exValid and (exLoad or exStore) -> capture exAddr/exData; assert memReq next cycle; go to WAIT; waitCount=0.
REQ-024 WAIT: memReq=1, memWrite held, memAddr/memWdata held stable; stall=1 combinationally in every WAIT cycle and in the IDLE cycle that launches a memory op.
REQ-025 WAIT and memAck=1: memReq drops the next cycle; go to DONE; latch memRdata for a load, or keep the captured exData for a store.
REQ-026 DONE lasts exactly one cycle: wbValid=1 (stores: wbValid=1, wbData=captured exData); stall=0; return to IDLE.
REQ-027 Minimum memory-op latency: accept at cycle N, memReq from N+1, ack at N+1, wbValid at N+2.
REQ-028 waitCount increments each WAIT cycle without ack; on reaching TIMEOUT, set fault=1, drop memReq, and go to IDLE with no wbValid.
REQ-029 memAck in the same cycle as timeout: the ack wins; no fault.
REQ-030 memAck outside WAIT is ignored.
REQ-031 flush in IDLE: the EX instruction is not accepted; no request; no wbValid.
REQ-032 flush in WAIT: memReq stays asserted until memAck (the bus is never abandoned); the result is discarded (DONE produces no wbValid); stall is released only after the ack.
REQ-033 flush in DONE: wbValid is suppressed.
REQ-034 fault is cleared only by reset.

Reset
REQ-035 With reset=1 at a clock edge, the block SHALL: set state=IDLE, memReq=0, memWrite=0, memAddr=0, memWdata=0, wbValid=0, wbData=0, fault=0, waitCount=0.
REQ-036 stall=0 during reset.
REQ-037 Reset mid-WAIT abandons the request immediately, with memReq=0 on the next cycle.

Verification
REQ-038 ALU op: exValid=1, exLoad=exStore=0, exData=0x00000005 -> next cycle wbValid=1, wbData=0x00000005, stall never 1.
REQ-039 Load with a 3-cycle ack: exLoad, exAddr=0x00001000; memAck after 3 WAIT cycles with memRdata=0xDEADBEEF -> memReq=1 with memAddr=0x1000 and memWrite=0 throughout; stall=1 until the ack; wbValid=1 with wbData=0xDEADBEEF one cycle after the ack.
REQ-040 Store with an immediate ack: exStore, exAddr=0x20, exData=0xA5A5A5A5 -> memWrite=1, memWdata=0xA5A5A5A5 for 1 cycle; wbValid two cycles after accept.
REQ-041 Timeout: load, memAck held 0, TIMEOUT=15 -> after 15 WAIT cycles fault=1, memReq=0, no wbValid; fault stays 1 until reset.
REQ-042 Flush in WAIT: load, flush=1 in the second WAIT cycle, ack in the fourth -> memReq held through the ack; no wbValid; stall drops after the ack.
REQ-043 Reset in WAIT: reset=1 -> next cycle all outputs 0 and state IDLE; a later ack produces no wbValid.
